tx_frame_scheduler: RTL

- Controller for the 4-ASK transmit chain (mapper -> 4x upsampler -> SRRC TX filter).
- Generates the sample and symbol clock enables that drive the whole chain.
- Sequences each frame as IDLE -> PREAMBLE -> PAYLOAD -> FLUSH and supplies `tx_data` to the mapper.
- Pulls payload symbols from an upstream source through a valid/ready handshake. Drives a mute flag to the mute mux at the mapper input.

---
 rtl/tx_frame_scheduler.sv | 78 +++++++
 1 files changed

// File: rtl/tx_frame_scheduler.sv
// tx_frame_scheduler: clock enables and IDLE/PREAMBLE/PAYLOAD/FLUSH sequencing for the 4-ASK TX chain
module tx_frame_scheduler #(
  parameter int SAM_DIV      = 4,
  parameter int PREAMBLE_LEN = 32,
  parameter int FLUSH_LEN    = 8,
  parameter int LEN_W        = 11
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] payload_len,
  input  logic [1:0]       data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             sam_clk_en,
  output logic             sym_clk_en,
  output logic [1:0]       tx_data,
  output logic             tx_mute,
  output logic             busy,
  output logic             underrun,
  output logic             frame_done
);
  localparam int SW = $clog2(SAM_DIV);
  typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, FLUSH} state_t;
  state_t state, state_n;
  logic [SW-1:0] sam_cnt;
  logic [1:0] sym_ph;
  logic [LEN_W-1:0] sym_cnt, len_q;
  logic start_pend, last;
  assign sam_clk_en = sam_cnt == SW'(SAM_DIV - 1);
  assign sym_clk_en = sam_clk_en && sym_ph == 2'd3;
  assign data_ready = state == PAYLOAD && sym_clk_en;
  assign busy = start_pend || state != IDLE;
  always_comb begin
    last = state == PREAMBLE ? sym_cnt == LEN_W'(PREAMBLE_LEN - 1) :
           state == PAYLOAD  ? sym_cnt == len_q - 1'b1 :
                               sym_cnt == LEN_W'(FLUSH_LEN - 1);
    state_n = !sym_clk_en      ? state :
              state == IDLE    ? (start_pend ? PREAMBLE : IDLE) :
              !last            ? state :
              state == PREAMBLE ? (len_q == '0 ? FLUSH : PAYLOAD) :
              state == PAYLOAD ? FLUSH : IDLE;
  end
  always_ff @(posedge sys_clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  // Each symbol period emits the symbol of the state it ran in at its closing edge
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      sam_cnt    <= '0;
      sym_ph     <= '0;
      sym_cnt    <= '0;
      len_q      <= '0;
      start_pend <= 1'b0;
      tx_data    <= 2'b00;
      tx_mute    <= 1'b1;
      underrun   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      sam_cnt    <= sam_clk_en ? '0 : sam_cnt + 1'b1;
      sym_ph     <= sam_clk_en ? sym_ph + 1'b1 : sym_ph;
      frame_done <= sym_clk_en && state == FLUSH && last;
      if (start && state == IDLE && !start_pend) begin
        start_pend <= 1'b1;
        len_q      <= payload_len;
        underrun   <= 1'b0;
      end
      if (sym_clk_en) begin
        if (state == IDLE && start_pend) start_pend <= 1'b0;
        sym_cnt <= (state == IDLE || last) ? '0 : sym_cnt + 1'b1;
        tx_data <= state == PREAMBLE ? {2{sym_cnt[0]}} :
                   data_ready && data_valid ? data_in : 2'b00;
        tx_mute <= !(state == PREAMBLE || state == PAYLOAD);
        if (data_ready && !data_valid) underrun <= 1'b1;
      end
    end
  end
endmodule
